// File: rtl/cpu_defs.sv
`default_nettype none
// ============================================================================
// Module   : cpu_defs (package)
// Purpose  : Shared CPU-wide constants: RoB tag width, number of result
//            producers on the common data bus, and producer identifiers.
// Revision : 1.0 - initial release
// ============================================================================
package cpu_defs;

    localparam int RoB_WIDTH = 3;
    localparam int NUM_REQ   = 3;

    // Width of the encoded producer id carried on the CDB
    localparam int SRC_W     = 2;

    localparam logic [SRC_W-1:0] SRC_ALU = 2'd0;
    localparam logic [SRC_W-1:0] SRC_LSB = 2'd1;
    localparam logic [SRC_W-1:0] SRC_BRU = 2'd2;

endpackage
`default_nettype wire

// File: rtl/rr_priority_picker.sv
`default_nettype none
// ============================================================================
// Module   : rr_priority_picker
// Purpose  : Combinational round-robin picker. Chooses the first asserted
//            request scanning from i_start upward, wrapping modulo N.
// Revision : 1.0 - initial release
// ============================================================================
module rr_priority_picker #(
    parameter int N  = 3,
    parameter int PW = 2
) (
    input  logic [N-1:0]  i_req,
    input  logic [PW-1:0] i_start,
    output logic [N-1:0]  o_grant,
    output logic [PW-1:0] o_winner,
    output logic          o_any
);

    logic [N-1:0] w_hi;

    // Prefer the lowest request at or above the start pointer; otherwise
    // wrap around and take the lowest request overall.
    always_comb begin
        w_hi     = '0;
        o_grant  = '0;
        o_winner = '0;
        o_any    = 1'b0;
        for (int j = 0; j < N; j++) begin
            w_hi[j] = i_req[j] && (j >= int'(i_start));
        end
        for (int j = N - 1; j >= 0; j--) begin
            if (i_req[j]) begin
                o_winner = PW'(j);
                o_any    = 1'b1;
            end
        end
        for (int j = N - 1; j >= 0; j--) begin
            if (w_hi[j]) begin
                o_winner = PW'(j);
            end
        end
        for (int j = 0; j < N; j++) begin
            o_grant[j] = o_any && (o_winner == PW'(j));
        end
    end

endmodule
`default_nettype wire

// File: rtl/cdb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : cdb_arbiter
// Purpose  : Common-data-bus arbiter. Each result producer owns a one-entry
//            holding slot; a round-robin picker selects one pending slot per
//            cycle and its tag/value are broadcast on a registered CDB.
// Revision : 1.0 - initial release
// ============================================================================
module cdb_arbiter #(
    parameter int RoB_WIDTH = cpu_defs::RoB_WIDTH,
    parameter int NUM_REQ   = cpu_defs::NUM_REQ
) (
    input  logic                         clk_in,
    input  logic                         rst_n_in,
    input  logic                         rdy_in,
    input  logic                         flush_signal,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*RoB_WIDTH-1:0] req_index,
    input  logic [NUM_REQ*32-1:0]        req_data,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic                         cdb_en,
    output logic [RoB_WIDTH-1:0]         cdb_index,
    output logic [31:0]                  cdb_data,
    output logic [1:0]                   cdb_src
);

    import cpu_defs::*;

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]   r_pend_valid;
    logic [RoB_WIDTH-1:0] r_pend_index [NUM_REQ];
    logic [31:0]          r_pend_data  [NUM_REQ];
    logic [PTR_W-1:0]     r_rr_ptr;

    logic [NUM_REQ-1:0]   w_grant;
    logic [PTR_W-1:0]     w_winner;
    logic                 w_any;
    logic                 w_run;
    logic [NUM_REQ-1:0]   w_xfer;
    logic [PTR_W-1:0]     w_next_ptr;

    rr_priority_picker #(
        .N  (NUM_REQ),
        .PW (PTR_W)
    ) u_picker (
        .i_req    (r_pend_valid),
        .i_start  (r_rr_ptr),
        .o_grant  (w_grant),
        .o_winner (w_winner),
        .o_any    (w_any)
    );

    // A slot accepts when running and either empty or being drained this cycle
    always_comb begin
        w_run      = rdy_in & ~flush_signal;
        req_ready  = {NUM_REQ{w_run}} & (~r_pend_valid | w_grant);
        w_xfer     = req_valid & req_ready;
        w_next_ptr = (int'(w_winner) == NUM_REQ - 1) ? '0 : w_winner + PTR_W'(1);
    end

    // Holding slots: reload wins over drain so a steady producer never bubbles
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_pend_valid <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                r_pend_index[i] <= '0;
                r_pend_data[i]  <= '0;
            end
        end else if (rdy_in) begin
            if (flush_signal) begin
                r_pend_valid <= '0;
            end else begin
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (w_xfer[i]) begin
                        r_pend_valid[i] <= 1'b1;
                        r_pend_index[i] <= req_index[i*RoB_WIDTH +: RoB_WIDTH];
                        r_pend_data[i]  <= req_data[i*32 +: 32];
                    end else if (w_grant[i]) begin
                        r_pend_valid[i] <= 1'b0;
                    end
                end
            end
        end
    end

    // Registered broadcast and round-robin pointer; everything frozen when paused
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            cdb_en    <= 1'b0;
            cdb_index <= '0;
            cdb_data  <= '0;
            cdb_src   <= '0;
            r_rr_ptr  <= '0;
        end else if (rdy_in) begin
            if (flush_signal) begin
                cdb_en   <= 1'b0;
                r_rr_ptr <= '0;
            end else if (w_any) begin
                cdb_en    <= 1'b1;
                cdb_index <= r_pend_index[w_winner];
                cdb_data  <= r_pend_data[w_winner];
                cdb_src   <= SRC_W'(w_winner);
                r_rr_ptr  <= w_next_ptr;
            end else begin
                cdb_en <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_cdb_arbiter
// Purpose  : Self-checking bench for cdb_arbiter: directed vector table plus
//            hand-written pause, flush and asynchronous-reset sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cdb_arbiter;

    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic        rdy_in;
    logic        flush_signal;
    logic [2:0]  req_valid;
    logic [8:0]  req_index;
    logic [95:0] req_data;
    logic [2:0]  req_ready;
    logic        cdb_en;
    logic [2:0]  cdb_index;
    logic [31:0] cdb_data;
    logic [1:0]  cdb_src;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        rst_before;
        logic        rdy;
        logic        flush;
        logic [2:0]  valid;
        logic [8:0]  idx;
        logic [95:0] data;
        logic [2:0]  exp_ready;
        logic        exp_en;
        logic [2:0]  exp_idx;
        logic [31:0] exp_data;
        logic [1:0]  exp_src;
    } vec_t;

    vec_t vq[$];

    cdb_arbiter dut (
        .clk_in       (clk_in),
        .rst_n_in     (rst_n_in),
        .rdy_in       (rdy_in),
        .flush_signal (flush_signal),
        .req_valid    (req_valid),
        .req_index    (req_index),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .cdb_en       (cdb_en),
        .cdb_index    (cdb_index),
        .cdb_data     (cdb_data),
        .cdb_src      (cdb_src)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic rdy, input logic fl, input logic [2:0] v,
                         input logic [8:0] ix, input logic [95:0] d);
        rdy_in       = rdy;
        flush_signal = fl;
        req_valid    = v;
        req_index    = ix;
        req_data     = d;
    endtask

    task automatic step;
        @(posedge clk_in);
        #1;
    endtask

    task automatic exp_cdb(input string nm, input logic en, input logic [2:0] ix,
                           input logic [31:0] d, input logic [1:0] s);
        chk({nm, ".en"},   32'(cdb_en),    32'(en));
        chk({nm, ".idx"},  32'(cdb_index), 32'(ix));
        chk({nm, ".data"}, cdb_data,       d);
        chk({nm, ".src"},  32'(cdb_src),   32'(s));
    endtask

    task automatic exp_rdy(input string nm, input logic [2:0] r);
        chk({nm, ".ready"}, 32'(req_ready), 32'(r));
    endtask

    task automatic do_reset;
        drive(1'b1, 1'b0, 3'b000, 9'd0, 96'd0);
        rst_n_in = 1'b0;
        repeat (2) @(posedge clk_in);
        #3;
        rst_n_in = 1'b1;
    endtask

    initial begin
        rst_n_in = 1'b0;
        drive(1'b0, 1'b0, 3'b000, 9'd0, 96'd0);

        // Single request from producer 0
        vq.push_back('{1'b1, 1'b1, 1'b0, 3'b001, {3'd0, 3'd0, 3'd5}, {32'd0, 32'd0, 32'hDEADBEEF},
                       3'b111, 1'b0, 3'd0, 32'd0, 2'd0});
        vq.push_back('{1'b0, 1'b1, 1'b0, 3'b000, 9'd0, 96'd0,
                       3'b111, 1'b1, 3'd5, 32'hDEADBEEF, 2'd0});
        vq.push_back('{1'b0, 1'b1, 1'b0, 3'b000, 9'd0, 96'd0,
                       3'b111, 1'b0, 3'd5, 32'hDEADBEEF, 2'd0});
        // All three producers streaming
        vq.push_back('{1'b1, 1'b1, 1'b0, 3'b111, {3'd3, 3'd2, 3'd1}, {32'h20, 32'h10, 32'h00},
                       3'b111, 1'b0, 3'd0, 32'h00, 2'd0});
        vq.push_back('{1'b0, 1'b1, 1'b0, 3'b111, {3'd3, 3'd2, 3'd1}, {32'h21, 32'h11, 32'h01},
                       3'b001, 1'b1, 3'd1, 32'h00, 2'd0});
        vq.push_back('{1'b0, 1'b1, 1'b0, 3'b111, {3'd3, 3'd2, 3'd1}, {32'h22, 32'h12, 32'h02},
                       3'b010, 1'b1, 3'd2, 32'h10, 2'd1});
        vq.push_back('{1'b0, 1'b1, 1'b0, 3'b111, {3'd3, 3'd2, 3'd1}, {32'h23, 32'h13, 32'h03},
                       3'b100, 1'b1, 3'd3, 32'h20, 2'd2});
        vq.push_back('{1'b0, 1'b1, 1'b0, 3'b111, {3'd3, 3'd2, 3'd1}, {32'h24, 32'h14, 32'h04},
                       3'b001, 1'b1, 3'd1, 32'h01, 2'd0});
        vq.push_back('{1'b0, 1'b1, 1'b0, 3'b111, {3'd3, 3'd2, 3'd1}, {32'h25, 32'h15, 32'h05},
                       3'b010, 1'b1, 3'd2, 32'h12, 2'd1});
        vq.push_back('{1'b0, 1'b1, 1'b0, 3'b111, {3'd3, 3'd2, 3'd1}, {32'h26, 32'h16, 32'h06},
                       3'b100, 1'b1, 3'd3, 32'h23, 2'd2});
        // Back-to-back from producer 1 only
        vq.push_back('{1'b1, 1'b1, 1'b0, 3'b010, {3'd0, 3'd1, 3'd0}, {32'd0, 32'hC1, 32'd0},
                       3'b111, 1'b0, 3'd0, 32'd0, 2'd0});
        vq.push_back('{1'b0, 1'b1, 1'b0, 3'b010, {3'd0, 3'd2, 3'd0}, {32'd0, 32'hC2, 32'd0},
                       3'b111, 1'b1, 3'd1, 32'hC1, 2'd1});
        vq.push_back('{1'b0, 1'b1, 1'b0, 3'b010, {3'd0, 3'd3, 3'd0}, {32'd0, 32'hC3, 32'd0},
                       3'b111, 1'b1, 3'd2, 32'hC2, 2'd1});
        vq.push_back('{1'b0, 1'b1, 1'b0, 3'b010, {3'd0, 3'd4, 3'd0}, {32'd0, 32'hC4, 32'd0},
                       3'b111, 1'b1, 3'd3, 32'hC3, 2'd1});
        vq.push_back('{1'b0, 1'b1, 1'b0, 3'b000, 9'd0, 96'd0,
                       3'b111, 1'b1, 3'd4, 32'hC4, 2'd1});
        vq.push_back('{1'b0, 1'b1, 1'b0, 3'b000, 9'd0, 96'd0,
                       3'b111, 1'b0, 3'd4, 32'hC4, 2'd1});

        for (int k = 0; k < vq.size(); k++) begin
            if (vq[k].rst_before) do_reset();
            drive(vq[k].rdy, vq[k].flush, vq[k].valid, vq[k].idx, vq[k].data);
            #1;
            exp_rdy($sformatf("vec%0d", k), vq[k].exp_ready);
            step();
            exp_cdb($sformatf("vec%0d", k), vq[k].exp_en, vq[k].exp_idx,
                    vq[k].exp_data, vq[k].exp_src);
        end

        // Pause while broadcasting tag 6, producer 1 still pending
        do_reset();
        drive(1'b1, 1'b0, 3'b011, {3'd0, 3'd2, 3'd6}, {32'd0, 32'h22, 32'h66});
        step();
        exp_cdb("pause.load", 1'b0, 3'd0, 32'd0, 2'd0);
        drive(1'b1, 1'b0, 3'b000, 9'd0, 96'd0);
        step();
        exp_cdb("pause.bc6", 1'b1, 3'd6, 32'h66, 2'd0);
        for (int p = 0; p < 3; p++) begin
            drive(1'b0, 1'b0, 3'b111, {3'd7, 3'd7, 3'd7}, {3{32'h77}});
            #1;
            exp_rdy($sformatf("pause.hold%0d", p), 3'b000);
            step();
            exp_cdb($sformatf("pause.hold%0d", p), 1'b1, 3'd6, 32'h66, 2'd0);
        end
        drive(1'b1, 1'b0, 3'b000, 9'd0, 96'd0);
        #1;
        exp_rdy("pause.resume", 3'b111);
        step();
        exp_cdb("pause.resume", 1'b1, 3'd2, 32'h22, 2'd1);
        step();
        exp_cdb("pause.idle0", 1'b0, 3'd2, 32'h22, 2'd1);
        step();
        exp_cdb("pause.idle1", 1'b0, 3'd2, 32'h22, 2'd1);

        // Flush with two slots pending and rr_ptr advanced to 1
        do_reset();
        drive(1'b1, 1'b0, 3'b001, {3'd0, 3'd0, 3'd7}, {32'd0, 32'd0, 32'h77});
        step();
        exp_cdb("flush.load", 1'b0, 3'd0, 32'd0, 2'd0);
        drive(1'b1, 1'b0, 3'b110, {3'd4, 3'd3, 3'd0}, {32'h44, 32'h33, 32'd0});
        #1;
        exp_rdy("flush.pre", 3'b111);
        step();
        exp_cdb("flush.pre", 1'b1, 3'd7, 32'h77, 2'd0);
        drive(1'b1, 1'b1, 3'b111, {3'd5, 3'd5, 3'd5}, {3{32'h55}});
        #1;
        exp_rdy("flush.cyc", 3'b000);
        step();
        exp_cdb("flush.cyc", 1'b0, 3'd7, 32'h77, 2'd0);
        drive(1'b1, 1'b0, 3'b101, {3'd2, 3'd0, 3'd1}, {32'h02, 32'd0, 32'h01});
        #1;
        exp_rdy("flush.post", 3'b111);
        step();
        exp_cdb("flush.nostale", 1'b0, 3'd7, 32'h77, 2'd0);
        drive(1'b1, 1'b0, 3'b000, 9'd0, 96'd0);
        step();
        exp_cdb("flush.first", 1'b1, 3'd1, 32'h01, 2'd0);
        step();
        exp_cdb("flush.second", 1'b1, 3'd2, 32'h02, 2'd2);
        step();
        exp_cdb("flush.idle", 1'b0, 3'd2, 32'h02, 2'd2);

        // Asynchronous reset mid-broadcast with producer 2 pending
        do_reset();
        drive(1'b1, 1'b0, 3'b001, {3'd0, 3'd0, 3'd3}, {32'd0, 32'd0, 32'h33});
        step();
        drive(1'b1, 1'b0, 3'b100, {3'd4, 3'd0, 3'd0}, {32'h44, 32'd0, 32'd0});
        step();
        exp_cdb("arst.pre", 1'b1, 3'd3, 32'h33, 2'd0);
        drive(1'b1, 1'b0, 3'b000, 9'd0, 96'd0);
        #2;
        rst_n_in = 1'b0;
        #1;
        exp_cdb("arst.async", 1'b0, 3'd0, 32'd0, 2'd0);
        @(posedge clk_in);
        #3;
        rst_n_in = 1'b1;
        step();
        exp_cdb("arst.empty0", 1'b0, 3'd0, 32'd0, 2'd0);
        step();
        exp_cdb("arst.empty1", 1'b0, 3'd0, 32'd0, 2'd0);
        drive(1'b1, 1'b0, 3'b101, {3'd2, 3'd0, 3'd1}, {32'hB2, 32'd0, 32'hB0});
        step();
        drive(1'b1, 1'b0, 3'b000, 9'd0, 96'd0);
        step();
        exp_cdb("arst.first", 1'b1, 3'd1, 32'hB0, 2'd0);
        step();
        exp_cdb("arst.second", 1'b1, 3'd2, 32'hB2, 2'd2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 Parameter RoB_WIDTH, default 3, SHALL set the RoB index width.
REQ-002 Parameter NUM_REQ, default 3, SHALL set the number of result producers.
REQ-003 Port clk_in, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst_n_in, input, 1, reset; reset SHALL be asynchronous and active-low.
REQ-005 Port rdy_in, input, 1, global run enable; low = pause.
REQ-006 Port flush_signal, input, 1, RoB misprediction flush.
REQ-007 Port req_valid, input, NUM_REQ, per-producer result valid.
REQ-008 Port req_index, input, NUM_REQ*RoB_WIDTH, per-producer RoB tag; producer i occupies slice i.
REQ-009 Port req_data, input, NUM_REQ*32, per-producer result value; producer i occupies slice i.
REQ-010 Port req_ready, output, NUM_REQ, per-producer accept; combinational.
REQ-011 Port cdb_en, output, 1, broadcast valid; registered.
REQ-012 Port cdb_index, output, RoB_WIDTH, broadcast RoB tag; registered.
REQ-013 Port cdb_data, output, 32, broadcast value; registered.
REQ-014 Port cdb_src, output, 2, index of the producer that won the broadcast; registered.

Function
REQ-015 Each producer i SHALL own one holding slot: pend_valid[i], pend_index[i], pend_data[i].
REQ-016 A transfer SHALL occur in a cycle when req_valid[i] and req_ready[i] are both high; the slot SHALL load at that clock edge.
REQ-017 req_ready[i] SHALL equal rdy_in & !flush_signal & (!pend_valid[i] | grant[i]), so a producer can sustain one result per cycle while it keeps winning.
REQ-018 grant SHALL be one-hot or zero, combinational from pend_valid and rr_ptr: the first valid slot scanning rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
REQ-019 On a grant to k with rdy_in high and no flush:
- cdb_en <= 1
- cdb_index <= pend_index[k]
- cdb_data <= pend_data[k]
- cdb_src <= k
- pend_valid[k] <= 0, unless it reloads the same cycle
- rr_ptr <= (k+1) mod NUM_REQ
REQ-020 With no grant, cdb_en SHALL go to 0 and index/data/src SHALL hold their values.
REQ-021 Latency: a result transferred in cycle c SHALL appear on the CDB in cycle c+2 at the earliest; waiting time SHALL be bounded by NUM_REQ-1 grants to other producers.
REQ-022 Simultaneous grant and reload of the same slot SHALL leave pend_valid=1 holding the new value.
REQ-023 While rdy_in=0 the block SHALL hold all state, including cdb_* outputs and rr_ptr, and force req_ready=0; each result SHALL therefore be broadcast exactly once when running resumes.
REQ-024 When flush_signal=1 and rdy_in=1, the next edge SHALL:
- clear all pend_valid
- set cdb_en <= 0
- set rr_ptr <= 0
- broadcast nothing and accept nothing that cycle
REQ-025 flush_signal SHALL take priority over grant and transfer in the same cycle.
REQ-026 rr_ptr SHALL be ceil(log2 NUM_REQ) bits wide and wrap from NUM_REQ-1 to 0.

Reset
REQ-027 While rst_n_in=0, the following SHALL be 0 immediately, independent of clk_in: pend_valid, pend_index, pend_data, rr_ptr, cdb_en, cdb_index, cdb_data, cdb_src.
REQ-028 Reset asserted mid-broadcast SHALL drop cdb_en at once; the first grant after release SHALL go to producer 0 if it is pending.

Structure
REQ-029 NUM_REQ, RoB_WIDTH and the producer IDs SRC_ALU=0, SRC_LSB=1 and SRC_BRU=2 SHALL live in the shared cpu_defs package.
REQ-030 Round-robin selection SHALL be a combinational sub-module rr_priority_picker (inputs: request vector and start pointer; outputs: one-hot grant and encoded winner).
REQ-031 Target size is 120-400 lines of RTL; the block SHALL contain no RoB state.

Verification
REQ-032 Single request: req_valid=001, idx=5, data=0xDEADBEEF in cycle 0 -> in cycle 2, cdb_en=1, cdb_index=5, cdb_data=0xDEADBEEF, cdb_src=0; cdb_en=0 in cycle 3.
REQ-033 All three producers valid every cycle from reset -> cdb_src sequence 0,1,2,0,1,2; no cycle with cdb_en=0 after the first broadcast; req_ready pattern matches the grants.
REQ-034 Back-to-back from producer 1 only (idx 1,2,3,4 on consecutive cycles) -> four consecutive broadcasts with idx 1,2,3,4 and req_ready[1] held high.
REQ-035 Pause: rdy_in=0 for 3 cycles while cdb_en=1, idx=6 -> outputs frozen; after resume, exactly one broadcast cycle with idx 6 and no duplicate.
REQ-036 Flush with two slots pending -> next cycle cdb_en=0 and no stale tag is ever broadcast; the first post-flush grant comes from rr_ptr=0.
REQ-037 Async reset asserted mid-cycle while cdb_en=1 -> cdb_en=0 before the next clk_in edge; all slots empty after release.
